// File: rtl/memory_bridge.sv
// memory_bridge: decodes the arbiter's single memory_* request into RAM,
// peripheral or unmapped space, forwards it as a registered downstream
// request and returns exactly one registered ready/error pulse upstream.
// Optional build macro: MEMORY_BRIDGE_TIMEOUT_EN (bounds the peripheral wait
// to TIMEOUT_CYCLES cycles; without it the peripheral may stall forever).
module memory_bridge #(
  parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
  parameter logic [31:0] RAM_SIZE       = 32'h0010_0000,
  parameter logic [31:0] PERIPH_BASE    = 32'h8000_0000,
  parameter logic [31:0] PERIPH_SIZE    = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memory_valid_i,
  input  logic        memory_instr_i,
  input  logic [31:0] memory_addr_i,
  input  logic [31:0] memory_wdata_i,
  input  logic [3:0]  memory_wstrb_i,
  output logic [31:0] memory_rdata_o,
  output logic        memory_error_o,
  output logic        memory_ready_o,
  output logic        ram_valid_o,
  output logic        ram_instr_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_wstrb_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_ready_i,
  output logic        periph_valid_o,
  output logic [31:0] periph_addr_o,
  output logic [31:0] periph_wdata_o,
  output logic [3:0]  periph_wstrb_o,
  input  logic [31:0] periph_rdata_i,
  input  logic        periph_ready_i,
  input  logic        periph_error_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAM    = 2'd1,
    ST_PERIPH = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t      state_q;
  logic        ram_valid_q, ram_instr_q;
  logic [31:0] ram_addr_q, ram_wdata_q;
  logic [3:0]  ram_wstrb_q;
  logic        periph_valid_q;
  logic [31:0] periph_addr_q, periph_wdata_q;
  logic [3:0]  periph_wstrb_q;
  logic        mem_ready_q, mem_error_q;
  logic [31:0] mem_rdata_q;

  logic ram_hit, periph_hit;

  // Region decode; RAM takes priority if the windows were ever to overlap.
  assign ram_hit    = (memory_addr_i & ~(RAM_SIZE - 32'd1)) == RAM_BASE;
  assign periph_hit = (memory_addr_i & ~(PERIPH_SIZE - 32'd1)) == PERIPH_BASE;

`ifdef MEMORY_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Request FSM; every output is a register so nothing upstream or downstream
  // sees a combinational path through the bridge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      ram_valid_q    <= 1'b0;
      ram_instr_q    <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_wstrb_q    <= '0;
      periph_valid_q <= 1'b0;
      periph_addr_q  <= '0;
      periph_wdata_q <= '0;
      periph_wstrb_q <= '0;
      mem_ready_q    <= 1'b0;
      mem_error_q    <= 1'b0;
      mem_rdata_q    <= '0;
`ifdef MEMORY_BRIDGE_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (memory_valid_i) begin
            if (ram_hit) begin
              ram_valid_q <= 1'b1;
              ram_instr_q <= memory_instr_i;
              ram_addr_q  <= memory_addr_i;
              ram_wdata_q <= memory_wdata_i;
              ram_wstrb_q <= memory_wstrb_i;
              state_q     <= ST_RAM;
            end else if (periph_hit) begin
              periph_valid_q <= 1'b1;
              periph_addr_q  <= memory_addr_i;
              periph_wdata_q <= memory_wdata_i;
              periph_wstrb_q <= memory_wstrb_i;
`ifdef MEMORY_BRIDGE_TIMEOUT_EN
              cnt_q          <= '0;
`endif
              state_q        <= ST_PERIPH;
            end else begin
              mem_error_q <= 1'b1;
              mem_rdata_q <= '0;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_RAM: begin
          if (ram_ready_i) begin
            ram_valid_q <= 1'b0;
            ram_instr_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wstrb_q <= '0;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= ram_rdata_i;
            state_q     <= ST_RESP;
          end
        end
        ST_PERIPH: begin
          if (periph_ready_i || periph_error_i) begin
            periph_valid_q <= 1'b0;
            periph_addr_q  <= '0;
            periph_wdata_q <= '0;
            periph_wstrb_q <= '0;
            mem_ready_q    <= ~periph_error_i;
            mem_error_q    <= periph_error_i;
            mem_rdata_q    <= periph_error_i ? 32'd0 : periph_rdata_i;
            state_q        <= ST_RESP;
          end
`ifdef MEMORY_BRIDGE_TIMEOUT_EN
          else if (cnt_q == CNT_LIMIT) begin
            periph_valid_q <= 1'b0;
            periph_addr_q  <= '0;
            periph_wdata_q <= '0;
            periph_wstrb_q <= '0;
            mem_error_q    <= 1'b1;
            mem_rdata_q    <= '0;
            state_q        <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_RESP: begin
          mem_ready_q <= 1'b0;
          mem_error_q <= 1'b0;
          mem_rdata_q <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign memory_rdata_o = mem_rdata_q;
  assign memory_error_o = mem_error_q;
  assign memory_ready_o = mem_ready_q;
  assign ram_valid_o    = ram_valid_q;
  assign ram_instr_o    = ram_instr_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_wdata_o    = ram_wdata_q;
  assign ram_wstrb_o    = ram_wstrb_q;
  assign periph_valid_o = periph_valid_q;
  assign periph_addr_o  = periph_addr_q;
  assign periph_wdata_o = periph_wdata_q;
  assign periph_wstrb_o = periph_wstrb_q;

endmodule

// File: tb/tb_memory_bridge.sv
// tb_memory_bridge: directed and randomized transactions against a
// transaction-level model of the bridge (address-range decode plus a
// per-transaction cycle timeline), checked every cycle.
module tb_memory_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        memory_valid_i = 1'b0;
  logic        memory_instr_i = 1'b0;
  logic [31:0] memory_addr_i = '0;
  logic [31:0] memory_wdata_i = '0;
  logic [3:0]  memory_wstrb_i = '0;
  logic [31:0] memory_rdata_o;
  logic        memory_error_o;
  logic        memory_ready_o;
  logic        ram_valid_o, ram_instr_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_wstrb_o;
  logic [31:0] ram_rdata_i = '0;
  logic        ram_ready_i = 1'b0;
  logic        periph_valid_o;
  logic [31:0] periph_addr_o, periph_wdata_o;
  logic [3:0]  periph_wstrb_o;
  logic [31:0] periph_rdata_i = '0;
  logic        periph_ready_i = 1'b0;
  logic        periph_error_i = 1'b0;

  int vectors = 0;
  int fails   = 0;

  typedef struct packed {
    logic        rv;
    logic        ri;
    logic [31:0] ra;
    logic [31:0] rw;
    logic [3:0]  rs;
    logic        pv;
    logic [31:0] pa;
    logic [31:0] pw;
    logic [3:0]  ps;
    logic        mr;
    logic        me;
    logic [31:0] md;
  } obs_t;

  memory_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .memory_valid_i(memory_valid_i), .memory_instr_i(memory_instr_i),
    .memory_addr_i(memory_addr_i), .memory_wdata_i(memory_wdata_i),
    .memory_wstrb_i(memory_wstrb_i), .memory_rdata_o(memory_rdata_o),
    .memory_error_o(memory_error_o), .memory_ready_o(memory_ready_o),
    .ram_valid_o(ram_valid_o), .ram_instr_o(ram_instr_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_wstrb_o(ram_wstrb_o), .ram_rdata_i(ram_rdata_i),
    .ram_ready_i(ram_ready_i), .periph_valid_o(periph_valid_o),
    .periph_addr_o(periph_addr_o), .periph_wdata_o(periph_wdata_o),
    .periph_wstrb_o(periph_wstrb_o), .periph_rdata_i(periph_rdata_i),
    .periph_ready_i(periph_ready_i), .periph_error_i(periph_error_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory map: 0 = RAM [0, 1 MiB), 1 = peripheral [2 GiB, 2 GiB + 64 KiB), 2 = unmapped
  function automatic int region(input logic [31:0] a);
    if (a < 32'h0010_0000) return 0;
    if (a >= 32'h8000_0000 && a < 32'h8001_0000) return 1;
    return 2;
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o = {ram_valid_o, ram_instr_o, ram_addr_o, ram_wdata_o, ram_wstrb_o,
         periph_valid_o, periph_addr_o, periph_wdata_o, periph_wstrb_o,
         memory_ready_o, memory_error_o, memory_rdata_o};
    vectors++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic idle(input string tag, input int n);
    memory_valid_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      check($sformatf("%s_idle%0d", tag, k), '0);
    end
  endtask

  // One request from presentation to its response pulse. w = downstream wait
  // cycles before completion; rd = downstream read data; derr/drdy = peripheral
  // completion flags; b2b = request presented during the previous response.
  task automatic run_txn(input string tag, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic instr, input int w, input logic [31:0] rd,
                         input bit derr, input bit drdy, input bit b2b);
    obs_t e;
    int   r;
    bit   err;
    r = region(addr);
    memory_valid_i = 1'b1;
    memory_addr_i  = addr;
    memory_wdata_i = wdata;
    memory_wstrb_i = wstrb;
    memory_instr_i = instr;
    if (b2b) begin
      @(negedge clk_i);
      check({tag, "_gap"}, '0);
    end
    if (r == 2) begin
      @(negedge clk_i);
      e = '0;
      e.me = 1'b1;
      check({tag, "_miss"}, e);
    end else begin
      for (int k = 1; k <= w + 1; k++) begin
        @(negedge clk_i);
        e = '0;
        if (r == 0) begin
          e.rv = 1'b1; e.ri = instr; e.ra = addr; e.rw = wdata; e.rs = wstrb;
        end else begin
          e.pv = 1'b1; e.pa = addr; e.pw = wdata; e.ps = wstrb;
        end
        check($sformatf("%s_req%0d", tag, k), e);
        if (k == w + 1) begin
          if (r == 0) begin
            ram_ready_i = 1'b1; ram_rdata_i = rd;
          end else begin
            periph_ready_i = drdy; periph_error_i = derr; periph_rdata_i = rd;
          end
        end else begin
          ram_rdata_i = $urandom; periph_rdata_i = $urandom;
        end
      end
      @(negedge clk_i);
      ram_ready_i = 1'b0; periph_ready_i = 1'b0; periph_error_i = 1'b0;
      ram_rdata_i = $urandom; periph_rdata_i = $urandom;
      err = (r == 1) && derr;
      e = '0;
      e.mr = !err;
      e.me = err;
      e.md = err ? 32'd0 : rd;
      check({tag, "_resp"}, e);
    end
    memory_valid_i = 1'b0;
  endtask

  initial begin
    obs_t e;
    logic [31:0] miss_tab [5];
    miss_tab[0] = 32'h0010_0000; miss_tab[1] = 32'h7FFF_FFFC;
    miss_tab[2] = 32'h8001_0000; miss_tab[3] = 32'hFFFF_FFFC;
    miss_tab[4] = 32'h4000_0000;

    // reset state
    #2 check("reset", '0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle("post_reset", 2);

    // directed scenarios
    run_txn("ram_read", 32'h0000_0100, 32'h0, 4'h0, 1'b0, 0, 32'hDEAD_BEEF, 0, 1, 0);
    idle("a", 1);
    run_txn("periph_write", 32'h8000_0004, 32'h1234_5678, 4'hF, 1'b0, 2, 32'h0, 0, 1, 0);
    idle("b", 1);
    run_txn("unmapped", 32'h4000_0000, 32'hAAAA_5555, 4'h3, 1'b0, 0, 32'h0, 0, 0, 0);
    idle("c", 1);
    run_txn("periph_err", 32'h8000_FFFC, 32'h0, 4'h0, 1'b0, 1, 32'hCAFE_F00D, 1, 1, 0);
    idle("d", 1);
    run_txn("b2b_first", 32'h0000_0040, 32'h0, 4'h0, 1'b1, 1, 32'h1111_2222, 0, 1, 0);
    run_txn("b2b_second", 32'h8000_0010, 32'h0, 4'h0, 1'b0, 0, 32'h3333_4444, 0, 1, 1);
    run_txn("b2b_third", 32'h0012_3456, 32'h0, 4'h1, 1'b0, 0, 32'h0, 0, 0, 1);
    idle("e", 1);
    run_txn("ram_top", 32'h000F_FFFC, 32'h5A5A_A5A5, 4'hC, 1'b0, 3, 32'h0BAD_F00D, 0, 1, 0);
    idle("f", 1);
    run_txn("ram_past_end", 32'h0010_0000, 32'h0, 4'h0, 1'b0, 0, 32'h0, 0, 0, 0);
    idle("g", 1);
    run_txn("periph_top", 32'h8000_FFFF, 32'h0, 4'h0, 1'b0, 0, 32'h7654_3210, 0, 1, 0);
    idle("h", 1);
    run_txn("periph_past_end", 32'h8001_0000, 32'h0, 4'h0, 1'b0, 0, 32'h0, 0, 0, 0);
    idle("i", 1);
    run_txn("periph_err_only", 32'h8000_0100, 32'h0, 4'h0, 1'b0, 0, 32'h9999_9999, 1, 0, 0);
    idle("j", 1);

    // reset in the middle of a RAM access: no response, clean restart
    memory_valid_i = 1'b1; memory_addr_i = 32'h0000_0200;
    memory_wdata_i = 32'hFEED_0001; memory_wstrb_i = 4'h5; memory_instr_i = 1'b0;
    e = '0; e.rv = 1'b1; e.ra = 32'h0000_0200; e.rw = 32'hFEED_0001; e.rs = 4'h5;
    @(negedge clk_i); check("rst_mid_req1", e);
    @(negedge clk_i); check("rst_mid_req2", e);
    rst_i = 1'b1;
    #1 check("rst_mid_async", '0);
    @(negedge clk_i);
    memory_valid_i = 1'b0;
    rst_i = 1'b0;
    idle("rst_mid", 3);
    run_txn("after_rst", 32'h0000_0300, 32'h0, 4'h0, 1'b1, 0, 32'h0123_4567, 0, 1, 0);
    idle("k", 1);

`ifdef MEMORY_BRIDGE_TIMEOUT_EN
    // silent peripheral: valid for 16 cycles, then an error response
    memory_valid_i = 1'b1; memory_addr_i = 32'h8000_0020;
    memory_wdata_i = 32'h0; memory_wstrb_i = 4'h0; memory_instr_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_i);
      e = '0; e.pv = 1'b1; e.pa = 32'h8000_0020;
      check($sformatf("timeout_req%0d", k), e);
    end
    @(negedge clk_i);
    e = '0; e.me = 1'b1;
    check("timeout_resp", e);
    idle("timeout", 1);
`endif

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int cat;
      bit b2b, derr, drdy;
      cat = $urandom_range(0, 2);
      if (cat == 0)      a = $urandom & 32'h000F_FFFF;
      else if (cat == 1) a = 32'h8000_0000 + ($urandom & 32'h0000_FFFF);
      else               a = miss_tab[$urandom_range(0, 4)];
      b2b  = (i > 0) && ($urandom_range(0, 1) == 1);
      derr = ($urandom_range(0, 3) == 0);
      drdy = derr ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!b2b) idle($sformatf("rnd%0d", i), $urandom_range(1, 2));
      run_txn($sformatf("rnd%0d", i), a, $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom,
              derr, drdy, b2b);
    end
    idle("final", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
